// File: rtl/dtree_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : dtree_sample_loader
// Description : Assembles byte-serial feature frames onto the tree input bus,
//               waits for the tree to settle, returns the class with an index.
// Revision    : 1.0 - initial release
// ============================================================================
module dtree_sample_loader #(
  parameter int NUM_FEATURES  = 6,
  parameter int FEAT_W        = 8,
  parameter int CLASS_W       = 2,
  parameter int SETTLE_CYCLES = 1,
  parameter int INDEX_W       = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_s_valid,
  output logic                           o_s_ready,
  input  logic [FEAT_W-1:0]              i_s_data,
  input  logic                           i_s_last,
  output logic [NUM_FEATURES*FEAT_W-1:0] o_feat_bus,
  input  logic [CLASS_W-1:0]             i_cls_in,
  output logic                           o_m_valid,
  input  logic                           i_m_ready,
  output logic [CLASS_W-1:0]             o_m_class,
  output logic [INDEX_W-1:0]             o_m_index,
  output logic                           o_err_frame
);

  localparam int CNT_W = $clog2(NUM_FEATURES);
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_cnt_last    = CNT_W'(NUM_FEATURES - 1);
  localparam logic [SET_W-1:0] c_settle_init = SET_W'(SETTLE_CYCLES);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_OUT    = 2'd2,
    ST_DROP   = 2'd3
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [CNT_W-1:0]                r_count;
  logic [CNT_W-1:0]                w_count_next;
  logic [SET_W-1:0]                r_settle;
  logic [SET_W-1:0]                w_settle_next;
  logic [NUM_FEATURES*FEAT_W-1:0]  r_feat_bus;
  logic                            r_m_valid;
  logic [CLASS_W-1:0]              r_m_class;
  logic [INDEX_W-1:0]              r_m_index;
  logic                            r_err;
  logic                            w_s_ready;
  logic                            w_write;
  logic                            w_err;
  logic                            w_capture;
  logic                            w_done;

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_settle_next = r_settle;
    w_s_ready     = 1'b0;
    w_write       = 1'b0;
    w_err         = 1'b0;
    w_capture     = 1'b0;
    w_done        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        w_s_ready = 1'b1;
        if (i_s_valid) begin
          w_write = 1'b1;
          if (r_count == c_cnt_last) begin
            w_count_next = '0;
            if (i_s_last) begin
              w_state_next  = ST_SETTLE;
              w_settle_next = c_settle_init;
            end else begin
              w_err        = 1'b1;
              w_state_next = ST_DROP;
            end
          end else if (i_s_last) begin
            // Short frame: the byte is still written, frame restarts at slot 0
            w_err        = 1'b1;
            w_count_next = '0;
          end else begin
            w_count_next = r_count + CNT_W'(1);
          end
        end
      end
      ST_DROP: begin
        w_s_ready = 1'b1;
        if (i_s_valid && i_s_last) begin
          w_state_next = ST_LOAD;
          w_count_next = '0;
        end
      end
      ST_SETTLE: begin
        if (r_settle == SET_W'(1)) begin
          w_capture    = 1'b1;
          w_state_next = ST_OUT;
        end else begin
          w_settle_next = r_settle - SET_W'(1);
        end
      end
      ST_OUT: begin
        if (i_m_ready) begin
          w_done       = 1'b1;
          w_state_next = ST_LOAD;
          w_count_next = '0;
        end
      end
      default: w_state_next = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LOAD;
      r_count   <= '0;
      r_settle  <= '0;
      r_m_valid <= 1'b0;
      r_m_class <= '0;
      r_m_index <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_settle <= w_settle_next;
      r_err    <= w_err;
      if (w_capture) begin
        r_m_valid <= 1'b1;
        r_m_class <= i_cls_in;
      end
      if (w_done) begin
        r_m_valid <= 1'b0;
        r_m_index <= r_m_index + INDEX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_feat_bus <= '0;
    end else begin
      for (int k = 0; k < NUM_FEATURES; k++) begin
        if (w_write && (r_count == CNT_W'(k))) begin
          r_feat_bus[k*FEAT_W +: FEAT_W] <= i_s_data;
        end
      end
    end
  end

  assign o_s_ready   = w_s_ready;
  assign o_feat_bus  = r_feat_bus;
  assign o_m_valid   = r_m_valid;
  assign o_m_class   = r_m_class;
  assign o_m_index   = r_m_index;
  assign o_err_frame = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dtree_sample_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_dtree_sample_loader
// Description : Directed self-checking bench; instance A uses defaults,
//               instance B uses INDEX_W=3 and SETTLE_CYCLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dtree_sample_loader;

  logic        clk;
  int          errors;
  int          checks;

  logic        rst_a, sv_a, rdy_a, sl_a, mv_a, mr_a, err_a;
  logic [7:0]  sd_a;
  logic [47:0] feat_a;
  logic [1:0]  cls_a, mcls_a;
  logic [15:0] idx_a;
  logic [7:0]  x_a;

  logic        rst_b, sv_b, rdy_b, sl_b, mv_b, mr_b, err_b;
  logic [7:0]  sd_b;
  logic [47:0] feat_b;
  logic [1:0]  cls_b, mcls_b;
  logic [2:0]  idx_b;
  logic [7:0]  x_b;

  // Stand-in tree: class = bits [2:1] of (X0 xor X5)
  assign x_a   = feat_a[7:0] ^ feat_a[47:40];
  assign cls_a = x_a[2:1];
  assign x_b   = feat_b[7:0] ^ feat_b[47:40];
  assign cls_b = x_b[2:1];

  dtree_sample_loader u_dut_a (
    .clk(clk), .rst(rst_a),
    .i_s_valid(sv_a), .o_s_ready(rdy_a), .i_s_data(sd_a), .i_s_last(sl_a),
    .o_feat_bus(feat_a), .i_cls_in(cls_a),
    .o_m_valid(mv_a), .i_m_ready(mr_a), .o_m_class(mcls_a), .o_m_index(idx_a),
    .o_err_frame(err_a)
  );

  dtree_sample_loader #(.SETTLE_CYCLES(4), .INDEX_W(3)) u_dut_b (
    .clk(clk), .rst(rst_b),
    .i_s_valid(sv_b), .o_s_ready(rdy_b), .i_s_data(sd_b), .i_s_last(sl_b),
    .o_feat_bus(feat_b), .i_cls_in(cls_b),
    .o_m_valid(mv_b), .i_m_ready(mr_b), .o_m_class(mcls_b), .o_m_index(idx_b),
    .o_err_frame(err_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_a(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    sv_a = 1'b1; sd_a = d; sl_a = l;
    @(negedge clk);
    while (!rdy_a && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_a) begin
      checks++; errors++;
      $display("FAIL send_a_timeout s_ready=%0b required=1", rdy_a);
    end
    @(posedge clk);
    #1;
    sv_a = 1'b0; sl_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    sv_b = 1'b1; sd_b = d; sl_b = l;
    @(negedge clk);
    while (!rdy_b && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_b) begin
      checks++; errors++;
      $display("FAIL send_b_timeout s_ready=%0b required=1", rdy_b);
    end
    @(posedge clk);
    #1;
    sv_b = 1'b0; sl_b = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    sv_a = 1'b0; sd_a = '0; sl_a = 1'b0; mr_a = 1'b0;
    sv_b = 1'b0; sd_b = '0; sl_b = 1'b0; mr_b = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;
    checks++;
    if (feat_a !== 48'h0 || mv_a !== 1'b0 || mcls_a !== 2'd0 || idx_a !== 16'd0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a feat=%h mv=%b cls=%0d idx=%0d err=%b required 0/0/0/0/0", feat_a, mv_a, mcls_a, idx_a, err_a);
    end
    checks++;
    if (rdy_a !== 1'b1 || rdy_b !== 1'b1 || mv_b !== 1'b0 || feat_b !== 48'h0 || idx_b !== 3'd0) begin
      errors++;
      $display("FAIL reset_ready rdy_a=%b rdy_b=%b mv_b=%b feat_b=%h idx_b=%0d required 1/1/0/0/0", rdy_a, rdy_b, mv_b, feat_b, idx_b);
    end
  endtask

  task automatic test_basic();
    for (int k = 0; k < 6; k++) send_a(8'(8'h0A + k), (k == 5));
    checks++;
    if (mv_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_settle m_valid=%b s_ready=%b required 0/0", mv_a, rdy_a);
    end
    @(posedge clk); #1;
    checks++;
    if (mv_a !== 1'b1 || mcls_a !== 2'd2 || idx_a !== 16'd0) begin
      errors++;
      $display("FAIL basic_result m_valid=%b class=%0d index=%0d required 1/2/0", mv_a, mcls_a, idx_a);
    end
    checks++;
    if (feat_a !== 48'h0F0E0D0C0B0A) begin
      errors++;
      $display("FAIL basic_bus feat_bus=%h required 0f0e0d0c0b0a", feat_a);
    end
  endtask

  task automatic test_backpressure();
    mr_a = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++;
      if (mv_a !== 1'b1 || mcls_a !== 2'd2 || feat_a !== 48'h0F0E0D0C0B0A || rdy_a !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d m_valid=%b class=%0d feat=%h s_ready=%b required 1/2/0f0e0d0c0b0a/0", c, mv_a, mcls_a, feat_a, rdy_a);
      end
    end
    mr_a = 1'b1;
    @(posedge clk); #1;
    mr_a = 1'b0;
    checks++;
    if (mv_a !== 1'b0 || idx_a !== 16'd1 || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL handshake m_valid=%b index=%0d s_ready=%b required 0/1/1", mv_a, idx_a, rdy_a);
    end
  endtask

  task automatic test_short_frame();
    send_a(8'h11, 1'b0); send_a(8'h22, 1'b0); send_a(8'h33, 1'b0); send_a(8'h44, 1'b1);
    checks++;
    if (err_a !== 1'b1 || mv_a !== 1'b0 || rdy_a !== 1'b1 || feat_a !== 48'h0F0E44332211) begin
      errors++;
      $display("FAIL short_err err=%b m_valid=%b s_ready=%b feat=%h required 1/0/1/0f0e44332211", err_a, mv_a, rdy_a, feat_a);
    end
    @(posedge clk); #1;
    checks++;
    if (err_a !== 1'b0 || mv_a !== 1'b0) begin
      errors++;
      $display("FAIL short_pulse err=%b m_valid=%b required 0/0", err_a, mv_a);
    end
    for (int k = 0; k < 6; k++) send_a(8'(k + 1), (k == 5));
    @(posedge clk); #1;
    checks++;
    if (mv_a !== 1'b1 || mcls_a !== 2'd3 || idx_a !== 16'd1 || feat_a !== 48'h060504030201) begin
      errors++;
      $display("FAIL short_recover m_valid=%b class=%0d index=%0d feat=%h required 1/3/1/060504030201", mv_a, mcls_a, idx_a, feat_a);
    end
    mr_a = 1'b1;
    @(posedge clk); #1;
    mr_a = 1'b0;
  endtask

  task automatic test_long_frame();
    for (int k = 0; k < 6; k++) send_a(8'(8'h10 * (k + 1)), 1'b0);
    checks++;
    if (err_a !== 1'b1 || rdy_a !== 1'b1 || feat_a !== 48'h605040302010) begin
      errors++;
      $display("FAIL long_err err=%b s_ready=%b feat=%h required 1/1/605040302010", err_a, rdy_a, feat_a);
    end
    send_a(8'h70, 1'b0);
    checks++;
    if (err_a !== 1'b0) begin
      errors++;
      $display("FAIL long_pulse err=%b required 0", err_a);
    end
    send_a(8'h80, 1'b0); send_a(8'h90, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (feat_a !== 48'h605040302010 || mv_a !== 1'b0 || err_a !== 1'b0) begin
      errors++;
      $display("FAIL long_drop feat=%h m_valid=%b err=%b required 605040302010/0/0", feat_a, mv_a, err_a);
    end
    send_a(8'h0C, 1'b0); send_a(8'hA1, 1'b0); send_a(8'hB2, 1'b0);
    send_a(8'hC3, 1'b0); send_a(8'hD4, 1'b0); send_a(8'h0A, 1'b1);
    @(posedge clk); #1;
    checks++;
    if (mv_a !== 1'b1 || mcls_a !== 2'd3 || idx_a !== 16'd2 || feat_a !== 48'h0AD4C3B2A10C) begin
      errors++;
      $display("FAIL long_recover m_valid=%b class=%0d index=%0d feat=%h required 1/3/2/0ad4c3b2a10c", mv_a, mcls_a, idx_a, feat_a);
    end
    mr_a = 1'b1;
    @(posedge clk); #1;
    mr_a = 1'b0;
  endtask

  task automatic test_index_wrap();
    int n;
    mr_b = 1'b1;
    for (int f = 0; f < 9; f++) begin
      for (int k = 0; k < 5; k++) send_b(8'(f * 16 + k * 3), 1'b0);
      send_b(8'(f * 16 + f), 1'b1);
      n = 0;
      while (!mv_b && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== 4 || idx_b !== 3'(f) || mcls_b !== 2'((f >> 1) & 3)) begin
        errors++;
        $display("FAIL wrap_f%0d latency=%0d index=%0d class=%0d required 4/%0d/%0d", f, n, idx_b, mcls_b, f % 8, (f >> 1) & 3);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (mv_b !== 1'b0 || idx_b !== 3'd1) begin
      errors++;
      $display("FAIL wrap_end m_valid=%b index=%0d required 0/1", mv_b, idx_b);
    end
    mr_b = 1'b0;
  endtask

  task automatic test_reset_in_settle();
    int bad;
    for (int k = 0; k < 6; k++) send_b(8'(8'h21 + k), (k == 5));
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    rst_b = 1'b0;
    checks++;
    if (mv_b !== 1'b0 || feat_b !== 48'h0 || rdy_b !== 1'b1 || idx_b !== 3'd0) begin
      errors++;
      $display("FAIL settle_reset m_valid=%b feat=%h s_ready=%b index=%0d required 0/0/1/0", mv_b, feat_b, rdy_b, idx_b);
    end
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (mv_b !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL settle_lost m_valid_cycles=%0d required 0", bad);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_short_frame();
    test_long_frame();
    test_index_wrap();
    test_reset_in_settle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
